// File: rtl/lcd_spi_rx.sv
// Receiver for the 4-wire LCD serial link: deserialises command/data bytes and pairs data bytes into 16-bit words.
// Define LCD_SPI_RX_WORD_EN to build the byte-pairing logic; otherwise word/word_valid are tied to 0.
module lcd_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_sck,
  input  logic        lcd_sdi,
  input  logic        lcd_dc,
  input  logic        lcd_cs_n,
  output logic [7:0]  rx_byte,
  output logic        cmd_valid,
  output logic        data_valid,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [15:0] data_count,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sckSr;
  logic [SYNC_STAGES-1:0] sdiSr;
  logic [SYNC_STAGES-1:0] dcSr;
  logic [SYNC_STAGES-1:0] csSr;
  logic                   sckS;
  logic                   sdiS;
  logic                   dcS;
  logic                   csS;
  logic                   sckPrev;
  logic                   csPrev;
  logic                   rise;
  logic                   csRise;

  state_t                 stateQ;
  state_t                 stateD;
  logic [2:0]             bitCnt;
  logic [2:0]             bitCntD;
  logic [6:0]             shifter;
  logic [6:0]             shiftD;
  logic                   byteDoneD;
  logic                   errD;

  logic                   doneQ;
  logic [7:0]             byteQ;
  logic                   dcQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      sckSr   <= '0;
      sdiSr   <= '0;
      dcSr    <= '0;
      csSr    <= '1;
      sckPrev <= 1'b0;
      csPrev  <= 1'b1;
    end else begin
      sckSr   <= {sckSr[SYNC_STAGES-2:0], lcd_sck};
      sdiSr   <= {sdiSr[SYNC_STAGES-2:0], lcd_sdi};
      dcSr    <= {dcSr[SYNC_STAGES-2:0], lcd_dc};
      csSr    <= {csSr[SYNC_STAGES-2:0], lcd_cs_n};
      sckPrev <= sckS;
      csPrev  <= csS;
    end
  end

  assign sckS   = sckSr[SYNC_STAGES-1];
  assign sdiS   = sdiSr[SYNC_STAGES-1];
  assign dcS    = dcSr[SYNC_STAGES-1];
  assign csS    = csSr[SYNC_STAGES-1];
  assign rise   = sckS & ~sckPrev;
  assign csRise = csS & ~csPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= IDLE;
      bitCnt  <= '0;
      shifter <= '0;
    end else begin
      stateQ  <= stateD;
      bitCnt  <= bitCntD;
      shifter <= shiftD;
    end
  end

  // A final bit arriving together with CS_n release still completes the byte.
  always_comb begin
    stateD    = stateQ;
    bitCntD   = bitCnt;
    shiftD    = shifter;
    byteDoneD = 1'b0;
    errD      = 1'b0;
    case (stateQ)
      IDLE: begin
        if (!csS) begin
          stateD  = SHIFT;
          bitCntD = '0;
        end
      end
      SHIFT: begin
        if (rise) begin
          shiftD  = {shifter[5:0], sdiS};
          bitCntD = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            byteDoneD = 1'b1;
          end
        end
        if (csS) begin
          stateD  = IDLE;
          bitCntD = '0;
          if ((bitCnt != 3'd0) && !byteDoneD) begin
            errD = 1'b1;
          end
        end
      end
      default: begin
        stateD  = IDLE;
        bitCntD = '0;
      end
    endcase
  end

  assign busy = (stateQ == SHIFT) && (bitCnt != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      doneQ     <= 1'b0;
      byteQ     <= '0;
      dcQ       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      doneQ     <= byteDoneD;
      frame_err <= errD;
      if (byteDoneD) begin
        byteQ <= {shifter, sdiS};
        dcQ   <= dcS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte    <= '0;
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      data_count <= '0;
    end else begin
      cmd_valid  <= doneQ & ~dcQ;
      data_valid <= doneQ & dcQ;
      if (doneQ) begin
        rx_byte <= byteQ;
        if (!dcQ) begin
          data_count <= '0;
        end else if (data_count != 16'hFFFF) begin
          data_count <= data_count + 16'd1;
        end
      end
    end
  end

`ifdef LCD_SPI_RX_WORD_EN
  logic       csRiseQ;
  logic       haveHigh;
  logic [7:0] hiByte;

  // CS_n rise is delayed to line up with the byte pipeline so a byte
  // finishing on that same edge is paired before the pairing resets.
  always_ff @(posedge clk) begin
    if (reset) begin
      csRiseQ    <= 1'b0;
      haveHigh   <= 1'b0;
      hiByte     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      csRiseQ    <= csRise;
      word_valid <= 1'b0;
      if (doneQ && !dcQ) begin
        haveHigh <= 1'b0;
      end else if (doneQ && dcQ) begin
        if (!haveHigh) begin
          hiByte   <= byteQ;
          haveHigh <= 1'b1;
        end else begin
          word       <= {hiByte, byteQ};
          word_valid <= 1'b1;
          haveHigh   <= 1'b0;
        end
      end
      if (csRiseQ) begin
        haveHigh <= 1'b0;
      end
    end
  end
`else
  logic unusedCsRise;
  assign unusedCsRise = csRise;
  assign word         = '0;
  assign word_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed self-checking bench for lcd_spi_rx: table-driven byte vectors plus framing, reset and latency sequences.
module tb_lcd_spi_rx;

`ifdef LCD_SPI_RX_WORD_EN
  localparam bit WordEn = 1'b1;
`else
  localparam bit WordEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        lcd_sck;
  logic        lcd_sdi;
  logic        lcd_dc;
  logic        lcd_cs_n;

  logic [7:0]  rx_byte, rx_byte3, rx_byte4;
  logic        cmd_valid, cmd_valid3, cmd_valid4;
  logic        data_valid, data_valid3, data_valid4;
  logic [15:0] word, word3, word4;
  logic        word_valid, word_valid3, word_valid4;
  logic [15:0] data_count, data_count3, data_count4;
  logic        frame_err, frame_err3, frame_err4;
  logic        busy, busy3, busy4;

  lcd_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .lcd_sck(lcd_sck), .lcd_sdi(lcd_sdi),
    .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .rx_byte(rx_byte),
    .cmd_valid(cmd_valid), .data_valid(data_valid), .word(word),
    .word_valid(word_valid), .data_count(data_count),
    .frame_err(frame_err), .busy(busy)
  );

  lcd_spi_rx #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .lcd_sck(lcd_sck), .lcd_sdi(lcd_sdi),
    .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .rx_byte(rx_byte3),
    .cmd_valid(cmd_valid3), .data_valid(data_valid3), .word(word3),
    .word_valid(word_valid3), .data_count(data_count3),
    .frame_err(frame_err3), .busy(busy3)
  );

  lcd_spi_rx #(.SYNC_STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .lcd_sck(lcd_sck), .lcd_sdi(lcd_sdi),
    .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .rx_byte(rx_byte4),
    .cmd_valid(cmd_valid4), .data_valid(data_valid4), .word(word4),
    .word_valid(word_valid4), .data_count(data_count4),
    .frame_err(frame_err4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/busy counters on the SYNC_STAGES=2 instance, sampled mid-cycle.
  int cmdSeen  = 0;
  int dataSeen = 0;
  int wordSeen = 0;
  int errSeen  = 0;
  int busySeen = 0;

  always @(negedge clk) begin
    if (cmd_valid)  cmdSeen++;
    if (data_valid) dataSeen++;
    if (word_valid) wordSeen++;
    if (frame_err)  errSeen++;
    if (busy)       busySeen++;
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCK at clk/8: 4 clk low with data set up, then 4 clk high.
  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      lcd_sck = 1'b0;
      lcd_sdi = b[i];
      waitNeg(4);
      lcd_sck = 1'b1;
      waitNeg(4);
    end
    lcd_sck = 1'b0;
    waitNeg(4);
  endtask

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    int          nCmd;
    int          nData;
    int          nWord;
    logic [7:0]  expByte;
    logic [15:0] expCount;
    logic [15:0] expWord;
  } vec_t;

  vec_t vecs[7];

  task automatic applyVec(input int i);
    int c0, d0, w0, e0;
    c0 = cmdSeen; d0 = dataSeen; w0 = wordSeen; e0 = errSeen;
    lcd_dc = vecs[i].dc;
    sendBits(vecs[i].b, 8);
    waitNeg(8);
    check($sformatf("v%0d_cmd_pulses", i),  cmdSeen - c0,  vecs[i].nCmd);
    check($sformatf("v%0d_data_pulses", i), dataSeen - d0, vecs[i].nData);
    check($sformatf("v%0d_word_pulses", i), wordSeen - w0, vecs[i].nWord);
    check($sformatf("v%0d_err_pulses", i),  errSeen - e0,  0);
    check($sformatf("v%0d_rx_byte", i),     rx_byte,       vecs[i].expByte);
    check($sformatf("v%0d_data_count", i),  data_count,    vecs[i].expCount);
    check($sformatf("v%0d_word", i),        word,          vecs[i].expWord);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, c0, d0, e0, w0;
    int lat2, lat3, lat4;
    logic [15:0] w7d7b, w1234;
    w7d7b = WordEn ? 16'h7D7B : 16'h0000;
    w1234 = WordEn ? 16'h1234 : 16'h0000;

    vecs[0] = '{1'b0, 8'h2C, 1, 0, 0, 8'h2C, 16'd0, 16'h0000};
    vecs[1] = '{1'b1, 8'h7D, 0, 1, 0, 8'h7D, 16'd1, 16'h0000};
    vecs[2] = '{1'b1, 8'h7B, 0, 1, int'(WordEn), 8'h7B, 16'd2, w7d7b};
    vecs[3] = '{1'b1, 8'h06, 0, 1, 0, 8'h06, 16'd3, w7d7b};
    vecs[4] = '{1'b0, 8'h01, 1, 0, 0, 8'h01, 16'd0, w7d7b};
    vecs[5] = '{1'b1, 8'h12, 0, 1, 0, 8'h12, 16'd1, w7d7b};
    vecs[6] = '{1'b1, 8'h34, 0, 1, int'(WordEn), 8'h34, 16'd2, w1234};

    reset = 1'b1; lcd_sck = 1'b0; lcd_sdi = 1'b0; lcd_dc = 1'b0; lcd_cs_n = 1'b1;
    waitNeg(5);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_count", data_count, 16'h0000);
    check("reset_word", word, 16'h0000);
    check("reset_flags", {cmd_valid, data_valid, word_valid, frame_err, busy}, 5'b0);
    reset = 1'b0;
    waitNeg(3);
    lcd_cs_n = 1'b0;
    waitNeg(6);

    // Command 0x2C then data 0x7D, 0x7B without CS toggle; busy spans bits 1..7.
    b0 = busySeen;
    applyVec(0);
    check("busy_cycles_cmd", busySeen - b0, 56);
    for (int i = 1; i <= 2; i++) applyVec(i);

    // Abort after 5 bits of 0xA5.
    d0 = dataSeen; e0 = errSeen;
    lcd_dc = 1'b1;
    sendBits(8'hA5, 5);
    lcd_cs_n = 1'b1;
    waitNeg(10);
    check("abort_err_pulses", errSeen - e0, 1);
    check("abort_data_pulses", dataSeen - d0, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_rx_byte", rx_byte, 8'h7B);
    check("abort_count", data_count, 16'd2);
    lcd_cs_n = 1'b0;
    waitNeg(6);
    applyVec(3);

    // SCK activity with CS_n high must be ignored.
    lcd_cs_n = 1'b1;
    waitNeg(6);
    c0 = cmdSeen; d0 = dataSeen; e0 = errSeen; w0 = wordSeen;
    lcd_dc = 1'b1;
    sendBits(8'h96, 8);
    waitNeg(8);
    check("csoff_pulses", (cmdSeen - c0) + (dataSeen - d0) + (errSeen - e0) + (wordSeen - w0), 0);
    check("csoff_rx_byte", rx_byte, 8'h06);
    check("csoff_count", data_count, 16'd3);
    check("csoff_word", word, w7d7b);
    lcd_cs_n = 1'b0;
    waitNeg(6);
    for (int i = 4; i <= 6; i++) applyVec(i);

    // Reset in the middle of a byte, then a clean 0xFF.
    e0 = errSeen;
    lcd_dc = 1'b1;
    sendBits(8'hE0, 3);
    reset = 1'b1;
    waitNeg(3);
    check("midreset_rx_byte", rx_byte, 8'h00);
    check("midreset_count", data_count, 16'h0000);
    check("midreset_word", word, 16'h0000);
    check("midreset_flags", {cmd_valid, data_valid, word_valid, frame_err, busy}, 5'b0);
    reset = 1'b0;
    waitNeg(6);
    d0 = dataSeen;
    sendBits(8'hFF, 8);
    waitNeg(8);
    check("postreset_rx_byte", rx_byte, 8'hFF);
    check("postreset_data_pulses", dataSeen - d0, 1);
    check("postreset_count", data_count, 16'd1);
    check("postreset_err_pulses", errSeen - e0, 0);

    // Pin-to-valid latency for each synchroniser depth, command 0x5A.
    lcd_dc = 1'b0;
    sendBits(8'h5A, 7);
    lcd_sck = 1'b0;
    lcd_sdi = 1'b0;
    waitNeg(4);
    lcd_sck = 1'b1;
    lat2 = 0; lat3 = 0; lat4 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (cmd_valid  && lat2 == 0) lat2 = k;
      if (cmd_valid3 && lat3 == 0) lat3 = k;
      if (cmd_valid4 && lat4 == 0) lat4 = k;
    end
    @(negedge clk);
    lcd_sck = 1'b0;
    waitNeg(6);
    check("latency_sync2", lat2, 4);
    check("latency_sync3", lat3, 5);
    check("latency_sync4", lat4, 6);
    check("end_rx_byte2", rx_byte, 8'h5A);
    check("end_rx_byte3", rx_byte3, 8'h5A);
    check("end_rx_byte4", rx_byte4, 8'h5A);
    check("end_count3", data_count3, 16'd0);
    check("end_count4", data_count4, 16'd0);
    check("end_word3", word3, 16'h0000);
    check("end_word4", word4, 16'h0000);
    check("end_flags3", {cmd_valid3, data_valid3, word_valid3, frame_err3, busy3}, 5'b0);
    check("end_flags4", {cmd_valid4, data_valid4, word_valid4, frame_err4, busy4}, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
